// File: rtl/mux_arb_pkg.sv
// Shared constants and state encoding for the two-requester round-robin result mux.
package mux_arb_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux32_2_1.sv
// Plain 2:1 data selector; select 0 passes i_a, select 1 passes i_b.
module MUX32_2_1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter sharing one result register between requesters A and B.
// Optional per-requester saturating grant counters enabled by MUX_ARB_STATS_EN.
module mux32_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef MUX_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A_req,
  input  logic [WIDTH-1:0] A_data,
  output logic             A_gnt,
  input  logic             B_req,
  input  logic [WIDTH-1:0] B_data,
  output logic             B_gnt,
  output logic             O_valid,
  output logic [WIDTH-1:0] O_data,
  input  logic             O_ready,
  output logic             Sel
`ifdef MUX_ARB_STATS_EN
  , output logic [CNT_W-1:0] A_cnt
  , output logic [CNT_W-1:0] B_cnt
`endif
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_sel;
  logic             r_last;
  logic             w_can_load;
  logic             w_any;
  logic             w_win;
  logic             w_gnt;
  logic [WIDTH-1:0] w_mux_data;

  assign w_can_load = (r_state == EMPTY) | O_ready;
  assign w_any      = A_req | B_req;
  // On contention the side that did not win last time goes next.
  assign w_win      = (A_req & B_req) ? ~r_last : (B_req ? SEL_B : SEL_A);
  assign w_gnt      = w_can_load & w_any & ~rst;

  assign A_gnt   = w_gnt & (w_win == SEL_A);
  assign B_gnt   = w_gnt & (w_win == SEL_B);
  assign O_valid = (r_state == FULL);
  assign O_data  = r_data;
  assign Sel     = r_sel;

  MUX32_2_1 #(.WIDTH(WIDTH)) u_mux (
    .i_a   (A_data),
    .i_b   (B_data),
    .i_sel (w_win),
    .o_y   (w_mux_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_gnt) w_state_nxt = FULL;
      FULL:    if (O_ready && !w_gnt) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_sel  <= SEL_A;
      r_last <= SEL_B;
    end else if (w_gnt) begin
      r_data <= w_mux_data;
      r_sel  <= w_win;
      r_last <= w_win;
    end
  end

`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0] r_a_cnt;
  logic [CNT_W-1:0] r_b_cnt;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_cnt <= '0;
      r_b_cnt <= '0;
    end else begin
      if (A_gnt && (r_a_cnt != '1)) r_a_cnt <= r_a_cnt + 1'b1;
      if (B_gnt && (r_b_cnt != '1)) r_b_cnt <= r_b_cnt + 1'b1;
    end
  end

  assign A_cnt = r_a_cnt;
  assign B_cnt = r_b_cnt;
`endif

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Scoreboard bench for mux32_rr_arbiter; build with MUX_ARB_STATS_EN to cover the counters.
module tb_mux32_rr_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         A_req, B_req, O_ready;
  logic [W-1:0] A_data, B_data;
  logic         A_gnt, B_gnt, O_valid, Sel;
  logic [W-1:0] O_data;
`ifdef MUX_ARB_STATS_EN
  localparam int CW = 4;
  logic [CW-1:0] A_cnt, B_cnt;
  logic [CW-1:0] m_acnt, m_bcnt;
`endif

  typedef struct packed {
    logic         sel;
    logic [W-1:0] data;
  } word_t;

  word_t  sb_q[$];
  logic   m_valid;
  logic   m_last;
  int     n_tests = 0;
  int     n_fail  = 0;

  always #5 clk = ~clk;

  mux32_rr_arbiter #(
    .WIDTH(W)
`ifdef MUX_ARB_STATS_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .A_req   (A_req),
    .A_data  (A_data),
    .A_gnt   (A_gnt),
    .B_req   (B_req),
    .B_data  (B_data),
    .B_gnt   (B_gnt),
    .O_valid (O_valid),
    .O_data  (O_data),
    .O_ready (O_ready),
    .Sel     (Sel)
`ifdef MUX_ARB_STATS_EN
    , .A_cnt (A_cnt)
    , .B_cnt (B_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input logic ar, input logic [W-1:0] ad, input logic br,
                     input logic [W-1:0] bd, input logic rdy, input int n);
    A_req = ar; A_data = ad; B_req = br; B_data = bd; O_ready = rdy;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: predicts grants at the falling edge and the effect of the next rising edge.
  always @(negedge clk) begin
    logic can, any, win, ega, egb;
    if (rst) begin
      chk("rst_a_gnt", A_gnt, 0);
      chk("rst_b_gnt", B_gnt, 0);
      chk("rst_o_valid", O_valid, 0);
      chk("rst_o_data", O_data, 0);
      chk("rst_sel", Sel, 0);
      m_valid = 1'b0;
      m_last  = 1'b1;
      sb_q.delete();
`ifdef MUX_ARB_STATS_EN
      m_acnt = '0;
      m_bcnt = '0;
      chk("rst_a_cnt", A_cnt, 0);
      chk("rst_b_cnt", B_cnt, 0);
`endif
    end else begin
      can = !m_valid || O_ready;
      any = A_req || B_req;
      win = (A_req && B_req) ? ~m_last : B_req;
      ega = can && any && !win;
      egb = can && any && win;
      chk("a_gnt", A_gnt, ega);
      chk("b_gnt", B_gnt, egb);
      chk("o_valid", O_valid, m_valid);
`ifdef MUX_ARB_STATS_EN
      chk("a_cnt", A_cnt, m_acnt);
      chk("b_cnt", B_cnt, m_bcnt);
      if (ega && m_acnt != '1) m_acnt = m_acnt + 1'b1;
      if (egb && m_bcnt != '1) m_bcnt = m_bcnt + 1'b1;
`endif
      if (m_valid && sb_q.size() > 0) begin
        chk("o_data", O_data, sb_q[0].data);
        chk("o_sel", Sel, sb_q[0].sel);
        if (O_ready) void'(sb_q.pop_front());
      end
      if (ega || egb) begin
        sb_q.push_back({win, win ? B_data : A_data});
        m_valid = 1'b1;
        m_last  = win;
      end else if (m_valid && O_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    A_req = 0; B_req = 0; O_ready = 0; A_data = '0; B_data = '0;
    #2;
    chk("por_o_valid", O_valid, 0);
    chk("por_o_data", O_data, 0);
    chk("por_sel", Sel, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Capture a word from A and hold it stalled, then reset with it pending.
    drv(1, 32'h11111111, 0, 32'h0, 0, 1);
    drv(0, 32'h11111111, 0, 32'h0, 0, 1);
    chk("pend_o_valid", O_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_o_valid", O_valid, 0);
    chk("midrst_o_data", O_data, 0);
    chk("midrst_sel", Sel, 0);
    drv(1, 32'hA0A0A0A0, 1, 32'hB0B0B0B0, 1, 1);
    rst = 1'b0;
    #1;
    chk("postrst_first_a", A_gnt, 1);
    chk("postrst_first_b", B_gnt, 0);
    // Continuous contention: alternation is tracked by the model.
    drv(1, 32'hA0A0A0A0, 1, 32'hB0B0B0B0, 1, 9);

    // Single requester A.
    A_req = 1; A_data = 32'hDEADBEEF; B_req = 0; O_ready = 1;
    #1;
    chk("deadbeef_gnt", A_gnt, 1);
    @(posedge clk);
    #1;
    A_req = 0;
    chk("deadbeef_valid", O_valid, 1);
    chk("deadbeef_data", O_data, 32'hDEADBEEF);
    chk("deadbeef_sel", Sel, 0);
    drv(0, 32'h0, 0, 32'h0, 1, 2);

    // Stall for 5 cycles with both waiting, then release.
    drv(1, 32'hCAFEF00D, 0, 32'h0, 1, 1);
    drv(1, 32'h12345678, 1, 32'h87654321, 0, 5);
    chk("stall_valid", O_valid, 1);
    chk("stall_data", O_data, 32'hCAFEF00D);
    drv(1, 32'h12345678, 1, 32'h87654321, 1, 3);

    // B only for three words, then contention goes to A.
    drv(0, 32'h0, 1, 32'hBBBB0001, 1, 1);
    drv(0, 32'h0, 1, 32'hBBBB0002, 1, 1);
    drv(0, 32'h0, 1, 32'hBBBB0003, 1, 1);
    A_req = 1; A_data = 32'hAAAA0004;
    #1;
    chk("b3_then_a", A_gnt, 1);
    drv(1, 32'hAAAA0004, 1, 32'hBBBB0004, 1, 2);
    drv(0, 32'h0, 0, 32'h0, 1, 2);

    // Random traffic and backpressure.
    for (int i = 0; i < 200; i++) begin
      drv($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
          ($urandom_range(0, 3) != 0), 1);
    end
    drv(0, 32'h0, 0, 32'h0, 1, 3);

`ifdef MUX_ARB_STATS_EN
    rst = 1'b1;
    drv(0, 32'h0, 0, 32'h0, 1, 1);
    rst = 1'b0;
    drv(0, 32'h0, 1, 32'h0B0B0B0B, 1, 3);
    drv(1, 32'h0A0A0A0A, 0, 32'h0, 1, 20);
    drv(0, 32'h0, 0, 32'h0, 1, 1);
    chk("a_cnt_sat", A_cnt, 4'hF);
    chk("b_cnt_3", B_cnt, 4'h3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux32_rr_arbiter.md
Name: mux32_rr_arbiter

Overview:
- Shares one 32-bit result path between two requesters (A, B) using round-robin arbitration.
- Drives the 2:1 select and captures the winner's word into a one-entry output register.
- Presents the captured word downstream with a valid/ready handshake.
- Sits in front of shared write/result ports in the CPU datapath (e.g. register-file write-back shared by ALU and memory paths).

Parameters:
- WIDTH, 32, data width of each requester and of the output.
- CNT_W, 16, width of the per-requester grant counters (only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- A_req  input  1  requester A has a valid word on A_data.
- A_data  input  WIDTH  requester A word.
- A_gnt  output  1  A's word is captured this cycle; A may drop or change its request.
- B_req  input  1  requester B valid.
- B_data  input  WIDTH  requester B word.
- B_gnt  output  1  B's word is captured this cycle.
- O_valid  output  1  O_data holds an unconsumed word.
- O_data  output  WIDTH  captured word.
- O_ready  input  1  downstream accepts O_data when O_valid=1.
- Sel  output  1  source of the word in O_data: 0=A, 1=B. Registered with O_data.
- A_cnt  output  CNT_W  grants to A (only with MUX_ARB_STATS_EN).
- B_cnt  output  CNT_W  grants to B (only with MUX_ARB_STATS_EN).

Behaviour:
- Reset (async, immediate):
  - O_valid=0, O_data=0, Sel=0.
  - last_gnt=B, so A wins the first contention.
  - Counters=0. A_gnt/B_gnt=0 while rst is high.
- Capture condition: can_load = !O_valid | O_ready. The buffer accepts a new word in the same cycle the old one drains, giving 1 word/cycle throughput.
- Arbitration is combinational in the current cycle:
  - Only A_req -> A wins. Only B_req -> B wins.
  - Both -> the requester not equal to last_gnt wins.
  - Neither -> no winner.
- Grant: X_gnt = can_load & winner==X. At most one grant per cycle; A_gnt and B_gnt are never both 1.
- On a grant (clock edge):
  - O_data <= winner data (through the 2:1 data mux).
  - Sel <= winner; O_valid <= 1; last_gnt <= winner.
- Drain: O_valid & O_ready with no grant -> O_valid <= 0. O_data and Sel hold their last values.
- Stall: O_valid & !O_ready:
  - No grants; O_data and Sel are stable.
  - Requesters hold X_req and X_data until granted. Dropping a request before its grant is legal and simply withdraws it.
- Latency: a request granted in cycle N appears with O_valid=1 in cycle N+1.
- Fairness: under continuous contention with O_ready=1, grants alternate A,B,A,B. No requester waits more than one other grant.
- Reset mid-transfer: the pending word is discarded and no grant is issued until rst falls. The first post-reset contention goes to A.
- Effective FSM states: EMPTY (O_valid=0) and FULL (O_valid=1).
  - EMPTY->FULL on grant.
  - FULL->FULL on stall, or on drain+grant.
  - FULL->EMPTY on drain with no request.

Optional Feature:
- MUX_ARB_STATS_EN defined:
  - A_cnt/B_cnt increment on each A_gnt/B_gnt respectively.
  - Counters saturate at all-ones (no wrap) and reset to 0.
- Not defined: the counter ports and logic are absent; arbitration behaviour is identical.

Decomposition:
- Package mux_arb_pkg:
  - WIDTH default constant.
  - SEL_A=1'b0 and SEL_B=1'b1 constants.
  - State encoding EMPTY/FULL.
- Sub-module: MUX32_2_1 instantiated for the data selection (A=A_data, B=B_data, Sel=winner). The arbiter owns only control and the output register.

Test Plan:
- Reset during O_valid=1 with A_data=32'h11111111 pending:
  - O_valid=0, O_data=0, Sel=0 immediately.
  - After release, both req -> A_gnt=1 first.
- A_req only, A_data=32'hDEADBEEF, O_ready=1:
  - A_gnt=1 in cycle N.
  - Cycle N+1: O_valid=1, O_data=32'hDEADBEEF, Sel=0.
- Both requesting continuously, O_ready=1, A=32'hA0A0A0A0, B=32'hB0B0B0B0:
  - Output sequence alternates A,B,A,B for 8 cycles.
  - Sel toggles 0,1,0,1; one word per cycle.
- O_ready=0 for 5 cycles with O_valid=1:
  - No grants; O_data and Sel constant.
  - Raising O_ready drains and captures the next winner in the same cycle.
- Only B requesting for 3 words, then A and B together:
  - B,B,B, then A wins (last_gnt=B).
- With MUX_ARB_STATS_EN and CNT_W=4:
  - 20 A grants -> A_cnt=4'hF (saturated).
  - B_cnt equals the number of B grants.
